// File: rtl/iterative_multiplier_if.sv
// iterative_multiplier_if
// Groups the request/response signals of the iterative multiplier.
//   start, op, rm, rs, acc_hi, acc_lo : request from the control unit
//   busy, done                         : handshake status from the unit
//   result_hi, result_lo               : 2*WIDTH-bit result (hi word 0 for short ops)
//   flag_n, flag_z                     : N/Z flags of the last result
// Modports: master = control unit side, slave = multiplier side.
interface iterative_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output start, op, rm, rs, acc_hi, acc_lo,
        input  busy, done, result_hi, result_lo, flag_n, flag_z
    );

    modport slave (
        input  start, op, rm, rs, acc_hi, acc_lo,
        output busy, done, result_hi, result_lo, flag_n, flag_z
    );
endinterface

// File: rtl/iterative_multiplier.sv
// iterative_multiplier
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit consuming BPC multiplier
// bits per cycle, with a start/busy/done handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : iterative_multiplier_if.slave (request operands, handshake, results, flags)
// op encoding: bit2 = long, bit1 = signed (long only), bit0 = accumulate.
module iterative_multiplier #(
    parameter int WIDTH      = 32,
    parameter int BPC        = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    iterative_multiplier_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;

    generate
        if (WIDTH % BPC != 0) begin : g_bad_bpc
            $error("iterative_multiplier: WIDTH must be a multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [W2-1:0]    acc, mcand, partial, acc_next;
    logic [WIDTH-1:0] mplier, rest;
    logic [BPC-1:0]   chunk;
    logic [CW-1:0]    cnt;
    logic             is_long, is_signed;
    logic             last, early, neg_msb;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             fn, fz;

    // mcand is pre-shifted each cycle so the current chunk always lines up
    // with bit 0 of the partial product. For signed ops the MSB of the final
    // chunk has weight -2^(BPC-1), handled by subtracting mcand<<BPC.
    always_comb begin
        chunk    = mplier[BPC-1:0];
        rest     = mplier >> BPC;
        last     = (cnt == CW'(N - 1));
        neg_msb  = is_signed && last && chunk[BPC-1];
        partial  = mcand * {{(W2-BPC){1'b0}}, chunk};
        acc_next = acc + partial - (neg_msb ? (mcand << BPC) : '0);
        early    = (EARLY_TERM != 0) && !is_signed && (rest == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last || early) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at acceptance, one chunk per CALC cycle, and result
    // registration on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            is_long   <= 1'b0;
            is_signed <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
            fn        <= 1'b0;
            fz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_long   <= bus.op[2];
                        is_signed <= bus.op[2] & bus.op[1];
                        cnt       <= '0;
                        mplier    <= bus.rs;
                        if (bus.op[2] & bus.op[1]) begin
                            mcand <= {{WIDTH{bus.rm[WIDTH-1]}}, bus.rm};
                        end else begin
                            mcand <= {{WIDTH{1'b0}}, bus.rm};
                        end
                        if (!bus.op[0]) begin
                            acc <= '0;
                        end else if (bus.op[2]) begin
                            acc <= {bus.acc_hi, bus.acc_lo};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, bus.acc_lo};
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BPC;
                    mplier <= rest;
                    cnt    <= cnt + CW'(1);
                    if (last || early) begin
                        if (is_long) begin
                            res_hi <= acc_next[W2-1:WIDTH];
                            res_lo <= acc_next[WIDTH-1:0];
                            fn     <= acc_next[W2-1];
                            fz     <= (acc_next == '0);
                        end else begin
                            res_hi <= '0;
                            res_lo <= acc_next[WIDTH-1:0];
                            fn     <= acc_next[WIDTH-1];
                            fz     <= (acc_next[WIDTH-1:0] == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;
    assign bus.flag_n    = fn;
    assign bus.flag_z    = fz;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier
// Drives two iterative_multiplier instances (EARLY_TERM=1 and EARLY_TERM=0)
// with identical requests and checks latency, handshake, results and flags
// against a plain-arithmetic reference model.
module tb_iterative_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iterative_multiplier_if #(.WIDTH(32)) if_e ();
    iterative_multiplier_if #(.WIDTH(32)) if_n ();

    iterative_multiplier #(.WIDTH(32), .BPC(8), .EARLY_TERM(1)) dut_e (
        .clk(clk), .rst(rst), .bus(if_e)
    );
    iterative_multiplier #(.WIDTH(32), .BPC(8), .EARLY_TERM(0)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n)
    );

    typedef struct packed {
        logic        done;
        logic        busy;
        logic [63:0] res;
        logic        n;
        logic        z;
    } snap_t;

    typedef struct packed {
        logic [7:0]  lat;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        busy_ok;
        logic        pulse_ok;
        logic [63:0] hold;
    } obs_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] ah;
        logic [31:0] al;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic [7:0]  le;
        logic [7:0]  ln;
    } vec_t;

    function automatic snap_t snap(input int d);
        snap_t s;
        if (d == 0) begin
            s.done = if_e.done; s.busy = if_e.busy;
            s.res  = {if_e.result_hi, if_e.result_lo};
            s.n    = if_e.flag_n; s.z = if_e.flag_z;
        end else begin
            s.done = if_n.done; s.busy = if_n.busy;
            s.res  = {if_n.result_hi, if_n.result_lo};
            s.n    = if_n.flag_n; s.z = if_n.flag_z;
        end
        return s;
    endfunction

    // Reference: {result, N, Z} from plain 64-bit arithmetic.
    function automatic logic [65:0] model(input logic [2:0] op, input logic [31:0] rm, rs, ah, al);
        logic [63:0] p;
        longint      a, b;
        if (op[2] && op[1]) begin
            a = longint'($signed(rm));
            b = longint'($signed(rs));
            p = 64'(a * b);
        end else begin
            p = {32'd0, rm} * {32'd0, rs};
        end
        if (op[0]) p = p + (op[2] ? {ah, al} : {32'd0, al});
        if (!op[2]) begin
            p = {32'd0, p[31:0]};
            return {p, p[31], p[31:0] == 32'd0};
        end
        return {p, p[63], p == 64'd0};
    endfunction

    // Cycles from acceptance to done: one per 8-bit chunk up to the last
    // non-zero one (at least one), all four when signed or early-term disabled.
    function automatic logic [7:0] exp_lat(input logic [2:0] op, input logic [31:0] rs, input bit et);
        int k;
        if (!et || (op[2] && op[1])) return 8'd5;
        k = 1;
        while (k < 4 && (rs >> (8 * k)) != 32'd0) k++;
        return 8'(k + 1);
    endfunction

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] rm, rs, ah, al);
        if_e.start = s; if_e.op = op; if_e.rm = rm; if_e.rs = rs; if_e.acc_hi = ah; if_e.acc_lo = al;
        if_n.start = s; if_n.op = op; if_n.rm = rm; if_n.rs = rs; if_n.acc_hi = ah; if_n.acc_lo = al;
    endtask

    // Issues one request at posedge+1 and follows both instances to done,
    // scrambling the inputs right after acceptance. Ends at posedge+1 in IDLE.
    task automatic do_op(input logic [2:0] op, input logic [31:0] rm, rs, ah, al,
                         output obs_t oe, output obs_t on);
        obs_t  o[2];
        snap_t s;
        int    k;
        o[0] = '0; o[1] = '0;
        o[0].busy_ok = 1'b1; o[1].busy_ok = 1'b1;
        drive(1'b1, op, rm, rs, ah, al);
        k = 0;
        while (k < 20 && (o[0].lat == 0 || o[1].lat == 0)) begin
            @(posedge clk); #1; k++;
            if (k == 1) drive(1'b0, 3'($urandom), $urandom, $urandom, $urandom, $urandom);
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                if (o[d].lat == 0) begin
                    if (s.done) begin
                        o[d].lat = 8'(k); o[d].res = s.res; o[d].n = s.n; o[d].z = s.z;
                        if (s.busy) o[d].busy_ok = 1'b0;
                    end else if (!s.busy) begin
                        o[d].busy_ok = 1'b0;
                    end
                end else if (k == int'(o[d].lat) + 1) begin
                    o[d].pulse_ok = !s.done && !s.busy;
                end
            end
        end
        @(posedge clk); #1; k++;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            if (o[d].lat != 0 && k == int'(o[d].lat) + 1) o[d].pulse_ok = !s.done && !s.busy;
            o[d].hold = s.res;
        end
        oe = o[0]; on = o[1];
    endtask

    task automatic test_reset();
        snap_t s;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            checks++;
            if ({s.busy, s.done} !== 2'b00) begin
                errors++; $display("[TB] FAIL reset handshake dut%0d: got %b expected 00", d, {s.busy, s.done});
            end
            checks++;
            if ({s.res, s.n, s.z} !== 66'd0) begin
                errors++; $display("[TB] FAIL reset outputs dut%0d: got %h expected 0", d, {s.res, s.n, s.z});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t       tbl[12];
        obs_t       o[2];
        logic [7:0] el[2];
        tbl[0]  = '{3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 64'h2A, 1'b0, 1'b0, 8'd2, 8'd5};
        tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5, 64'h3, 1'b0, 1'b0, 8'd2, 8'd5};
        tbl[2]  = '{3'b000, 32'd0, 32'h1234, 32'd0, 32'd0, 64'h0, 1'b0, 1'b1, 8'd3, 8'd5};
        tbl[3]  = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 64'hFFFFFFFE_00000001, 1'b1, 1'b0, 8'd5, 8'd5};
        tbl[4]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000, 1'b1, 1'b0, 8'd5, 8'd5};
        tbl[5]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 64'h0, 1'b0, 1'b1, 8'd5, 8'd5};
        tbl[6]  = '{3'b110, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFF1, 1'b1, 1'b0, 8'd5, 8'd5};
        tbl[7]  = '{3'b111, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd15, 64'h0, 1'b0, 1'b1, 8'd5, 8'd5};
        tbl[8]  = '{3'b100, 32'h1234, 32'h10, 32'd0, 32'd0, 64'h12340, 1'b0, 1'b0, 8'd2, 8'd5};
        tbl[9]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 64'h1, 1'b0, 1'b0, 8'd5, 8'd5};
        tbl[10] = '{3'b001, 32'd2, 32'd3, 32'hDEAD, 32'd1, 64'h7, 1'b0, 1'b0, 8'd2, 8'd5};
        tbl[11] = '{3'b110, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b1, 1'b0, 8'd5, 8'd5};
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].rm, tbl[i].rs, tbl[i].ah, tbl[i].al, o[0], o[1]);
            el[0] = tbl[i].le; el[1] = tbl[i].ln;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o[d].lat !== el[d]) begin
                    errors++; $display("[TB] FAIL dir%0d dut%0d latency: got %0d expected %0d", i, d, o[d].lat, el[d]);
                end
                checks++;
                if ({o[d].res, o[d].n, o[d].z} !== {tbl[i].res, tbl[i].n, tbl[i].z}) begin
                    errors++; $display("[TB] FAIL dir%0d dut%0d result: got %h n%b z%b expected %h n%b z%b",
                                       i, d, o[d].res, o[d].n, o[d].z, tbl[i].res, tbl[i].n, tbl[i].z);
                end
                checks++;
                if (o[d].busy_ok !== 1'b1) begin
                    errors++; $display("[TB] FAIL dir%0d dut%0d busy window: got %b expected 1", i, d, o[d].busy_ok);
                end
                checks++;
                if (o[d].pulse_ok !== 1'b1) begin
                    errors++; $display("[TB] FAIL dir%0d dut%0d done pulse: got %b expected 1", i, d, o[d].pulse_ok);
                end
                checks++;
                if (o[d].hold !== tbl[i].res) begin
                    errors++; $display("[TB] FAIL dir%0d dut%0d hold: got %h expected %h", i, d, o[d].hold, tbl[i].res);
                end
            end
        end
    endtask

    task automatic test_random();
        obs_t        o[2];
        logic [7:0]  el[2];
        logic [65:0] exp_v;
        logic [63:0] m;
        logic [2:0]  op;
        logic [31:0] rm, rs, ah, al;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            rm = $urandom;
            m  = (64'd1 << (8 * $urandom_range(0, 4))) - 64'd1;
            rs = $urandom & m[31:0];
            ah = $urandom;
            al = $urandom;
            exp_v = model(op, rm, rs, ah, al);
            el[0] = exp_lat(op, rs, 1'b1);
            el[1] = exp_lat(op, rs, 1'b0);
            do_op(op, rm, rs, ah, al, o[0], o[1]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o[d].lat !== el[d]) begin
                    errors++; $display("[TB] FAIL rnd%0d dut%0d latency op%b rs=%h: got %0d expected %0d", i, d, op, rs, o[d].lat, el[d]);
                end
                checks++;
                if ({o[d].res, o[d].n, o[d].z} !== exp_v) begin
                    errors++; $display("[TB] FAIL rnd%0d dut%0d result op%b rm=%h rs=%h: got %h expected %h",
                                       i, d, op, rm, rs, {o[d].res, o[d].n, o[d].z}, exp_v);
                end
                checks++;
                if ({o[d].busy_ok, o[d].pulse_ok} !== 2'b11) begin
                    errors++; $display("[TB] FAIL rnd%0d dut%0d handshake: got %b expected 11", i, d, {o[d].busy_ok, o[d].pulse_ok});
                end
                checks++;
                if (o[d].hold !== exp_v[65:2]) begin
                    errors++; $display("[TB] FAIL rnd%0d dut%0d hold: got %h expected %h", i, d, o[d].hold, exp_v[65:2]);
                end
            end
        end
    endtask

    // start held high through DONE is taken in the following IDLE cycle.
    task automatic test_back_to_back();
        int          k, mx, extra;
        int          k1[2], k2[2], ek1[2], ek2[2];
        logic [63:0] r1[2], r2[2];
        snap_t       s;
        k1 = '{0, 0}; k2 = '{0, 0}; r1 = '{64'd0, 64'd0}; r2 = '{64'd0, 64'd0};
        ek1 = '{2, 5}; ek2 = '{6, 11};
        extra = 0;
        drive(1'b1, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
        k = 0;
        while (k < 30 && (k2[0] == 0 || k2[1] == 0)) begin
            @(posedge clk); #1; k++;
            if (k == 1) drive(1'b1, 3'b000, 32'h11, 32'h0202, 32'd0, 32'd0);
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                if (s.done) begin
                    if (k1[d] == 0) begin k1[d] = k; r1[d] = s.res; end
                    else if (k2[d] == 0) begin k2[d] = k; r2[d] = s.res; end
                end
            end
            mx = (k1[0] > k1[1]) ? k1[0] : k1[1];
            if (k1[0] != 0 && k1[1] != 0 && k >= mx + 2) if_e.start = 1'b0;
            if (k1[0] != 0 && k1[1] != 0 && k >= mx + 2) if_n.start = 1'b0;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
            if (if_e.done || if_n.done) extra++;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (k1[d] !== ek1[d] || k2[d] !== ek2[d]) begin
                errors++; $display("[TB] FAIL b2b dut%0d done cycles: got %0d,%0d expected %0d,%0d", d, k1[d], k2[d], ek1[d], ek2[d]);
            end
            checks++;
            if (r1[d] !== 64'h2A || r2[d] !== 64'h2222) begin
                errors++; $display("[TB] FAIL b2b dut%0d results: got %h,%h expected 2a,2222", d, r1[d], r2[d]);
            end
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("[TB] FAIL b2b extra done: got %0d expected 0", extra);
        end
    endtask

    task automatic test_control();
        int          k, extra;
        int          lat[2];
        logic [63:0] r[2];
        logic [65:0] exp_v;
        logic [31:0] rm, rs, ah, al;
        snap_t       s;
        obs_t        o[2];
        lat = '{0, 0}; r = '{64'd0, 64'd0}; extra = 0;
        // Second start during CALC must be dropped.
        drive(1'b1, 3'b000, 32'd3, 32'h01010101, 32'd0, 32'd0);
        k = 0;
        while (k < 24 && (lat[0] == 0 || lat[1] == 0)) begin
            @(posedge clk); #1; k++;
            if (k == 1) drive(1'b0, 3'b000, 32'd3, 32'h01010101, 32'd0, 32'd0);
            if (k == 2) drive(1'b1, 3'b100, 32'd9, 32'd9, 32'd0, 32'd0);
            if (k == 3) drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            for (int d = 0; d < 2; d++) begin
                s = snap(d);
                if (s.done && lat[d] == 0) begin lat[d] = k; r[d] = s.res; end
            end
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (if_e.done || if_n.done) extra++;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lat[d] !== 5 || r[d] !== 64'h03030303) begin
                errors++; $display("[TB] FAIL ignore-start dut%0d: got lat %0d res %h expected lat 5 res 03030303", d, lat[d], r[d]);
            end
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("[TB] FAIL ignore-start queued op: got %0d done pulses expected 0", extra);
        end
        // Reset in the middle of CALC.
        drive(1'b1, 3'b000, 32'd5, 32'h01000000, 32'd0, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            s = snap(d);
            checks++;
            if (s !== '0) begin
                errors++; $display("[TB] FAIL midop reset dut%0d: got %h expected 0", d, s);
            end
        end
        @(posedge clk);
        #4 rst = 1'b0;
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if_e.done || if_n.done || if_e.busy || if_n.busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("[TB] FAIL post-reset activity: got %0d cycles expected 0", extra);
        end
        // A fresh request after reset completes normally.
        rm = $urandom; rs = $urandom; ah = $urandom; al = $urandom;
        exp_v = model(3'b111, rm, rs, ah, al);
        do_op(3'b111, rm, rs, ah, al, o[0], o[1]);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o[d].lat !== 8'd5 || {o[d].res, o[d].n, o[d].z} !== exp_v) begin
                errors++; $display("[TB] FAIL after-reset op dut%0d: got lat %0d %h expected lat 5 %h",
                                   d, o[d].lat, {o[d].res, o[d].n, o[d].z}, exp_v);
            end
        end
    endtask

    initial begin
        $display("[TB] iterative_multiplier bench start");
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_control();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
